// File: rtl/wled_pkg.sv
// Shared types and helpers for the LED frame scheduler: FSM states, index width,
// GRB field offsets and the channel-word builder.
package wled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } wled_state_e;

    localparam int LED_NUM_W = 8;

    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    // Each set colour bit drives its channel to 'level', clear bits give 0.
    function automatic logic [23:0] grb_word(input logic       g,
                                             input logic       r,
                                             input logic       b,
                                             input logic [7:0] level);
        logic [23:0] w;
        w = '0;
        w[G_LSB +: 8] = g ? level : 8'h00;
        w[R_LSB +: 8] = r ? level : 8'h00;
        w[B_LSB +: 8] = b ? level : 8'h00;
        return w;
    endfunction

endpackage

// File: rtl/wled_refresh_timer.sv
// Periodic refresh timer: raises expire_o for one cycle every REFRESH_MS*CLK_MHZ*1000
// cycles; reload_i restarts the period. REFRESH_MS=0 keeps the timer silent.
module wled_refresh_timer
    import wled_pkg::*;
#(
    parameter int CLK_MHZ    = 27,
    parameter int REFRESH_MS = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload_i,
    output logic expire_o
);

    localparam logic [31:0] PERIOD    = 32'(REFRESH_MS * CLK_MHZ * 1000);
    localparam logic        TIMER_OFF = (REFRESH_MS == 0);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        at_end;

    assign at_end   = (cnt_q == PERIOD - 32'd1);
    assign expire_o = at_end && !TIMER_OFF;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (reload_i || at_end || TIMER_OFF) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wled_scheduler.sv
// Change-driven frame scheduler feeding a ws2812 driver one LED word per 3 cycles.
// Optional build macro WLED_BRIGHT_EN adds an 8-bit brightness input that scales LEVEL.
module wled_scheduler
    import wled_pkg::*;
#(
    parameter int CLK_MHZ    = 27,
    parameter int NUM_LEDS   = 1,
    parameter int LEVEL      = 255,
    parameter int REFRESH_MS = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] green,
    input  logic [NUM_LEDS-1:0] red,
    input  logic [NUM_LEDS-1:0] blue,
`ifdef WLED_BRIGHT_EN
    input  logic [7:0]          brightness,
`endif
    output logic [23:0]         rgb_data,
    output logic [7:0]          led_num,
    output logic                write,
    output logic                busy,
    output logic                frame_done
);

`ifdef WLED_BRIGHT_EN
    localparam int SNAP_W = 3 * NUM_LEDS + 8;
`else
    localparam int SNAP_W = 3 * NUM_LEDS;
`endif

    localparam logic [LED_NUM_W-1:0] LAST_LED = LED_NUM_W'(NUM_LEDS - 1);
    localparam logic [7:0]           LEVEL_B  = 8'(LEVEL);

    wled_state_e          state_q, state_d;
    logic [LED_NUM_W-1:0] led_q, led_d;
    logic [SNAP_W-1:0]    commit_q, commit_d;
    logic [SNAP_W-1:0]    buf_q, buf_d;
    logic                 force_q, force_d;
    logic                 done_q, done_d;
    logic                 start;
    logic                 expire;
    logic [SNAP_W-1:0]    snap;
    logic                 g_bit, r_bit, b_bit;
    logic [7:0]           on_level;

    // Buffer layout, LSB first: blue, red, green, then brightness when present.
`ifdef WLED_BRIGHT_EN
    assign snap     = {brightness, green, red, blue};
    assign on_level = 8'(({8'h00, LEVEL_B} * {8'h00, buf_q[3*NUM_LEDS +: 8]}) >> 8);
`else
    assign snap     = {green, red, blue};
    assign on_level = LEVEL_B;
`endif

    wled_refresh_timer #(
        .CLK_MHZ   (CLK_MHZ),
        .REFRESH_MS(REFRESH_MS)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload_i(start),
        .expire_o(expire)
    );

    always_comb begin
        g_bit = 1'b0;
        r_bit = 1'b0;
        b_bit = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (led_q == LED_NUM_W'(i)) begin
                b_bit = buf_q[i];
                r_bit = buf_q[NUM_LEDS + i];
                g_bit = buf_q[2*NUM_LEDS + i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        commit_d = commit_q;
        buf_d    = buf_q;
        force_d  = force_q | expire;
        done_d   = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A frame start absorbs a same-cycle timer expiry.
                if (enable && ((snap != commit_q) || force_q)) begin
                    start    = 1'b1;
                    buf_d    = snap;
                    commit_d = snap;
                    force_d  = 1'b0;
                    led_d    = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (led_q == LAST_LED) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    led_d   = led_q + LED_NUM_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            led_q    <= '0;
            commit_q <= '0;
            buf_q    <= '0;
            force_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            commit_q <= commit_d;
            buf_q    <= buf_d;
            force_q  <= force_d;
            done_q   <= done_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign write      = (state_q == ST_WRITE);
    assign frame_done = done_q;
    assign led_num    = led_q;
    assign rgb_data   = busy ? grb_word(g_bit, r_bit, b_bit, on_level) : 24'h000000;

endmodule
